// File: rtl/bram_arbiter_if.sv
// Bus bundle between the BRAM arbiter, its two requesters (CPU port A, debug port B)
// and the single-port data BRAM.
interface bram_arbiter_if #(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32
) ();
    logic                    i_a_req;
    logic                    i_a_we;
    logic [ADDRESS_BITS-1:0] i_a_address;
    logic [DATA_BITS-1:0]    i_a_data;
    logic                    o_a_ack;
    logic [DATA_BITS-1:0]    o_a_data;

    logic                    i_b_req;
    logic                    i_b_we;
    logic [ADDRESS_BITS-1:0] i_b_address;
    logic [DATA_BITS-1:0]    i_b_data;
    logic                    o_b_ack;
    logic [DATA_BITS-1:0]    o_b_data;

    logic                    i_lock;
    logic                    o_busy;

    logic                    o_bram_we;
    logic [ADDRESS_BITS-1:0] o_bram_address;
    logic [DATA_BITS-1:0]    o_bram_data;
    logic [DATA_BITS-1:0]    i_bram_data;

    modport master (
        output i_a_req, i_a_we, i_a_address, i_a_data,
        output i_b_req, i_b_we, i_b_address, i_b_data,
        output i_lock, i_bram_data,
        input  o_a_ack, o_a_data, o_b_ack, o_b_data,
        input  o_busy, o_bram_we, o_bram_address, o_bram_data
    );

    modport slave (
        input  i_a_req, i_a_we, i_a_address, i_a_data,
        input  i_b_req, i_b_we, i_b_address, i_b_data,
        input  i_lock, i_bram_data,
        output o_a_ack, o_a_data, o_b_ack, o_b_data,
        output o_busy, o_bram_we, o_bram_address, o_bram_data
    );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the CPU (A) and debug unit (B),
// with a debug lock that blocks new A grants.
//
// state  | meaning
// IDLE   | waiting for an eligible request; winner latched on exit
// ACCESS | latched address/data/we driven to the BRAM for one cycle
// DONE   | one-cycle ack to the winner
module bram_arbiter #(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32
) (
    input logic           clk,
    input logic           rst,
    bram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    grant, grant_b;
    logic                    elig_a, elig_b;
    logic                    lat_b, lat_we, last_b;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0]    data_q;
    logic [DATA_BITS-1:0]    a_data_q, b_data_q;

    assign elig_a = bus.i_a_req && !bus.i_lock;
    assign elig_b = bus.i_b_req;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (elig_a || elig_b) begin
                    grant     = 1'b1;
                    // on a tie, the port not served last wins
                    grant_b   = elig_b && (!elig_a || !last_b);
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            lat_b    <= 1'b0;
            lat_we   <= 1'b0;
            last_b   <= 1'b1;
            addr_q   <= '0;
            data_q   <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                lat_b  <= grant_b;
                last_b <= grant_b;
                lat_we <= grant_b ? bus.i_b_we      : bus.i_a_we;
                addr_q <= grant_b ? bus.i_b_address : bus.i_a_address;
                data_q <= grant_b ? bus.i_b_data    : bus.i_a_data;
            end
            if (state == ACCESS && !lat_we) begin
                if (lat_b) b_data_q <= bus.i_bram_data;
                else       a_data_q <= bus.i_bram_data;
            end
        end
    end

    // addr_q only moves on a grant, so the BRAM address holds between accesses
    assign bus.o_bram_we      = (state == ACCESS) && lat_we;
    assign bus.o_bram_address = addr_q;
    assign bus.o_bram_data    = data_q;
    assign bus.o_a_ack        = (state == DONE) && !lat_b;
    assign bus.o_b_ack        = (state == DONE) && lat_b;
    assign bus.o_a_data       = a_data_q;
    assign bus.o_b_data       = b_data_q;
    assign bus.o_busy         = (state != IDLE);
endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: per-port expected queues filled at issue time from a
// reference memory, drained by a negedge monitor whenever an ack appears.
module tb_bram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.ADDRESS_BITS(8), .DATA_BITS(32)) ifc ();
    bram_arbiter #(.ADDRESS_BITS(8), .DATA_BITS(32)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        bit          we;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          ack_log[$];   // 0 = A, 1 = B
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] a_last, b_last;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          a_ack_cnt = 0;

    // BRAM model: write on rising edge, read data presented on falling edge
    always @(posedge clk) if (ifc.o_bram_we) mem[ifc.o_bram_address] = ifc.o_bram_data;
    always @(negedge clk) ifc.i_bram_data = mem[ifc.o_bram_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifc.o_bram_we) we_cnt++;
        if (ifc.o_a_ack && ifc.o_b_ack) check("dual_ack", 32'd1, 32'd0);
        if (ifc.o_a_ack) begin
            a_ack_cnt++;
            ack_log.push_back(0);
            check("a_ack_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                if (!e.we) a_last = e.data;
                check(e.we ? "a_data_held" : "a_rdata", ifc.o_a_data, a_last);
            end
        end
        if (ifc.o_b_ack) begin
            ack_log.push_back(1);
            check("b_ack_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                if (!e.we) b_last = e.data;
                check(e.we ? "b_data_held" : "b_rdata", ifc.o_b_data, b_last);
            end
        end
    end

    task automatic txn(input bit pb, input bit we, input logic [7:0] addr,
                       input logic [31:0] data, input bit chk_lat);
        exp_t e;
        int   n = 0;
        bit   seen = 0;
        e.we   = we;
        e.data = we ? data : ref_mem[addr];
        if (we) ref_mem[addr] = data;
        if (pb) qb.push_back(e);
        else    qa.push_back(e);
        @(posedge clk); #1;
        if (pb) begin
            ifc.i_b_req = 1; ifc.i_b_we = we; ifc.i_b_address = addr; ifc.i_b_data = data;
        end else begin
            ifc.i_a_req = 1; ifc.i_a_we = we; ifc.i_a_address = addr; ifc.i_a_data = data;
        end
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = pb ? ifc.o_b_ack : ifc.o_a_ack;
        end
        if (!seen) check(pb ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
        else if (chk_lat) check("ack_latency", n, 3);
        @(posedge clk); #1;
        if (pb) ifc.i_b_req = 0;
        else    ifc.i_a_req = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        ifc.i_a_req = 0;
        ifc.i_b_req = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        a_last = 0;
        b_last = 0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        ifc.i_a_req = 0; ifc.i_a_we = 0; ifc.i_a_address = 0; ifc.i_a_data = 0;
        ifc.i_b_req = 0; ifc.i_b_we = 0; ifc.i_b_address = 0; ifc.i_b_data = 0;
        ifc.i_lock = 0;
        do_reset();

        check("rst_busy", 32'(ifc.o_busy), 0);
        check("rst_ack", {30'd0, ifc.o_a_ack, ifc.o_b_ack}, 0);
        check("rst_bram_we", 32'(ifc.o_bram_we), 0);
        check("rst_bram_addr", 32'(ifc.o_bram_address), 0);
        check("rst_bram_data", ifc.o_bram_data, 0);
        check("rst_a_data", ifc.o_a_data, 0);
        check("rst_b_data", ifc.o_b_data, 0);

        // B write then read
        we_cnt = 0;
        a_ack_cnt = 0;
        txn(1, 1, 8'h10, 32'hDEADBEEF, 1);
        check("write_we_cycles", we_cnt, 1);
        txn(1, 0, 8'h10, 32'h0, 1);
        check("b_read_deadbeef", ifc.o_b_data, 32'hDEADBEEF);
        check("a_ack_silent", a_ack_cnt, 0);

        // A reads initial contents
        txn(0, 0, 8'h05, 32'h0, 1);
        check("a_read_init", ifc.o_a_data, 32'h5);

        // Contention: A and B continuously requesting
        do_reset();
        ack_log.delete();
        fork
            for (int i = 0; i < 3; i++) txn(0, 0, 8'(8'h20 + i), 32'h0, 0);
            for (int i = 0; i < 3; i++) txn(1, 0, 8'(8'h40 + i), 32'h0, 0);
        join
        check("contention_count", ack_log.size(), 6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            check("contention_order", ack_log[i], i % 2);

        // Lock: only B served until lock drops, then A
        ack_log.delete();
        ifc.i_lock = 1;
        fork
            txn(0, 0, 8'h30, 32'h0, 0);
            begin
                txn(1, 1, 8'h50, 32'h12345678, 0);
                txn(1, 0, 8'h50, 32'h0, 0);
                ifc.i_lock = 0;
            end
        join
        check("lock_count", ack_log.size(), 3);
        for (int i = 0; i < 3 && i < ack_log.size(); i++)
            check("lock_order", ack_log[i], (i < 2) ? 1 : 0);

        // Reset during ACCESS of a B read
        @(posedge clk); #1;
        ifc.i_b_req = 1; ifc.i_b_we = 0; ifc.i_b_address = 8'h60;
        @(posedge clk); #1;
        check("mid_busy_access", 32'(ifc.o_busy), 1);
        rst = 0;
        ifc.i_b_req = 0;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(ifc.o_busy), 0);
        check("mid_rst_ack", {30'd0, ifc.o_a_ack, ifc.o_b_ack}, 0);
        check("mid_rst_bram_we", 32'(ifc.o_bram_we), 0);
        check("mid_rst_bram_addr", 32'(ifc.o_bram_address), 0);
        check("mid_rst_bram_data", ifc.o_bram_data, 0);
        check("mid_rst_b_data", ifc.o_b_data, 0);
        check("mid_rst_a_data", ifc.o_a_data, 0);
        a_last = 0;
        b_last = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        check("mid_rst_no_ack", 32'(ifc.o_b_ack), 0);

        // Address boundaries
        txn(1, 1, 8'hFF, 32'hA5A5_0FFF, 1);
        txn(1, 1, 8'h00, 32'h5A5A_F000, 1);
        txn(1, 0, 8'hFE, 32'h0, 1);
        txn(1, 0, 8'hFF, 32'h0, 1);
        txn(1, 0, 8'h00, 32'h0, 1);
        txn(1, 0, 8'h01, 32'h0, 1);

        // Random traffic, disjoint address halves per port
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom, 0);
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom, 0);
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
